// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word/line widths, L2 arbiter state and grant encodings.
package lc3b_types;

    localparam int unsigned WORD_WIDTH   = 16;
    localparam int unsigned C_LINE_WIDTH = 128;
    localparam int unsigned PERF_WIDTH   = 16;

    typedef logic [WORD_WIDTH-1:0]   lc3b_word;
    typedef logic [C_LINE_WIDTH-1:0] lc3b_c_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } l2_arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } l2_arb_grant_t;

endpackage

// File: rtl/l2_arb_sat_counter.sv
// Saturating event counter used for the optional arbiter performance statistics.
module l2_arb_sat_counter
    import lc3b_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    output logic [PERF_WIDTH-1:0] count
);

    localparam logic [PERF_WIDTH-1:0] COUNT_MAX = {PERF_WIDTH{1'b1}};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + PERF_WIDTH'(1);
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-cache and the D-side write-back path.
// Define L2_ARB_PERF_EN to add saturating grant/conflict counters.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_WIDTH = WORD_WIDTH,
    parameter int unsigned LINE_WIDTH = C_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
`ifdef L2_ARB_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_i_grants,
    output logic [PERF_WIDTH-1:0] perf_d_grants,
    output logic [PERF_WIDTH-1:0] perf_conflicts
`endif
);

    l2_arb_state_t state;
    l2_arb_state_t state_next;
    l2_arb_grant_t last_grant;
    l2_arb_grant_t last_grant_next;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic conflict;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // State register; after reset the D side counts as last served so I wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Next-state: grants only from IDLE, which forces a bubble after every completion.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        conflict        = 1'b0;
        case (state)
            IDLE: begin
                conflict = i_req & d_req;
                if (conflict) begin
                    grant_i = (last_grant == GRANT_D);
                    grant_d = (last_grant == GRANT_I);
                end else begin
                    grant_i = i_req;
                    grant_d = d_req;
                end
                if (grant_i) begin
                    state_next      = SERVE_I;
                    last_grant_next = GRANT_I;
                end else if (grant_d) begin
                    state_next      = SERVE_D;
                    last_grant_next = GRANT_D;
                end
            end
            SERVE_I: begin
                if (l2_resp) begin
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                if (l2_resp) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output mux: the granted side is wired straight through; a write wins over a read on D.
    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_addr  = '0;
        l2_wdata = '0;
        i_rdata  = '0;
        i_resp   = 1'b0;
        d_rdata  = '0;
        d_resp   = 1'b0;
        case (state)
            SERVE_I: begin
                l2_read = 1'b1;
                l2_addr = i_addr;
                i_rdata = l2_rdata;
                i_resp  = l2_resp;
            end
            SERVE_D: begin
                l2_write = d_write;
                l2_read  = d_read & ~d_write;
                l2_addr  = d_addr;
                l2_wdata = d_wdata;
                d_rdata  = l2_rdata;
                d_resp   = l2_resp;
            end
            default: begin
            end
        endcase
    end

`ifdef L2_ARB_PERF_EN
    l2_arb_sat_counter u_perf_i_grants (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (grant_i),
        .count (perf_i_grants)
    );

    l2_arb_sat_counter u_perf_d_grants (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (grant_d),
        .count (perf_d_grants)
    );

    l2_arb_sat_counter u_perf_conflicts (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (conflict),
        .count (perf_conflicts)
    );
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomized self-checking bench for l2_arbiter against a transaction-level arbitration model.
module tb_l2_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] l2_rdata;
    logic          l2_resp;
`ifdef L2_ARB_PERF_EN
    logic [15:0]   perf_i_grants;
    logic [15:0]   perf_d_grants;
    logic [15:0]   perf_conflicts;
`endif

    l2_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .l2_read  (l2_read),
        .l2_write (l2_write),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_rdata (l2_rdata),
        .l2_resp  (l2_resp)
`ifdef L2_ARB_PERF_EN
        ,
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: which side the arbitration rules say owns L2, and who won last.
    int owner;       // 0 none, 1 I, 2 D
    int last_win;
    int lat_left;
    int d_kind;      // 0 read, 1 write, 2 read+write
    bit i_done;
    bit d_done;
    int completions;
    int i_budget;
    int d_budget;
    int raise_pct;
    int force_lat;
    int force_dkind;
    bit use_fix_i;
    bit use_fix_d;
    logic [AW-1:0] fix_i_addr;
    logic [AW-1:0] fix_d_addr;

    logic [LW-1:0] ref_mem [int unsigned];
    logic [LW-1:0] l2_mem  [int unsigned];

    int win_log[$];
    int gap_log[$];
    bit gap_open;
    int gap_cnt;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] fill(input logic [AW-1:0] a);
        return {8{a}};
    endfunction

    function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(32'(a)) ? ref_mem[32'(a)] : fill(a);
    endfunction

    function automatic logic [LW-1:0] l2_rd(input logic [AW-1:0] a);
        return l2_mem.exists(32'(a)) ? l2_mem[32'(a)] : fill(a);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 7)) << 4;
    endfunction

    function automatic int pick_kind();
        int r;
        r = int'($urandom_range(0, 9));
        return (r < 5) ? 0 : ((r < 9) ? 1 : 2);
    endfunction

    task automatic may_raise(inout int budget, output bit go);
        go = 1'b0;
        if (budget != 0 && int'($urandom_range(1, 100)) <= raise_pct) begin
            go = 1'b1;
            if (budget > 0) budget--;
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_l2_read"},  l2_read,  0);
        check({pfx, "_l2_write"}, l2_write, 0);
        check({pfx, "_l2_addr"},  l2_addr,  0);
        check({pfx, "_l2_wdata"}, l2_wdata, 0);
        check({pfx, "_i_resp"},   i_resp,   0);
        check({pfx, "_d_resp"},   d_resp,   0);
        check({pfx, "_i_rdata"},  i_rdata,  0);
        check({pfx, "_d_rdata"},  d_rdata,  0);
    endtask

    task automatic model_reset();
        owner       = 0;
        last_win    = 2;
        i_done      = 1'b0;
        d_done      = 1'b0;
        completions = 0;
        gap_open    = 1'b0;
        gap_cnt     = 0;
        win_log.delete();
        gap_log.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        i_read   = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        i_addr   = '0;
        d_addr   = '0;
        d_wdata  = '0;
        l2_resp  = 1'b0;
        l2_rdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        ref_mem.delete();
        l2_mem.delete();
        force_lat   = -1;
        force_dkind = -1;
        use_fix_i   = 1'b0;
        use_fix_d   = 1'b0;
        #1;
        check_idle_outputs("rst");
`ifdef L2_ARB_PERF_EN
        check("rst_perf_i", perf_i_grants, 0);
        check("rst_perf_d", perf_d_grants, 0);
        check("rst_perf_conf", perf_conflicts, 0);
`endif
    endtask

    // One clock of requesters + L2 model + checks + reference update.
    task automatic cycle();
        bit go;
        bit resp_now;
        int nxt;
        if (i_done) begin
            i_read = 1'b0;
            i_done = 1'b0;
        end
        if (d_done) begin
            d_read  = 1'b0;
            d_write = 1'b0;
            d_done  = 1'b0;
        end
        if (!i_read) begin
            may_raise(i_budget, go);
            if (go) begin
                i_read = 1'b1;
                i_addr = use_fix_i ? fix_i_addr : rand_addr();
            end
        end
        if (!d_read && !d_write) begin
            may_raise(d_budget, go);
            if (go) begin
                d_kind  = (force_dkind >= 0) ? force_dkind : pick_kind();
                d_read  = (d_kind != 1);
                d_write = (d_kind != 0);
                d_addr  = use_fix_d ? fix_d_addr : rand_addr();
                d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        #1;
        resp_now = (owner != 0) && (lat_left == 0);
        l2_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        l2_resp  = resp_now;
        if (owner == 0) l2_resp = ($urandom_range(0, 7) == 0);
        else if (resp_now && !l2_write) l2_rdata = l2_rd(l2_addr);
        #1;
        if (owner == 0) begin
            check_idle_outputs("idle");
        end else if (owner == 1) begin
            check("i_l2_read",  l2_read,  1);
            check("i_l2_write", l2_write, 0);
            check("i_l2_addr",  l2_addr,  i_addr);
            check("i_resp",     i_resp,   resp_now);
            check("i_other_d_resp", d_resp, 0);
            if (resp_now) check("i_rdata", i_rdata, ref_rd(i_addr));
        end else begin
            check("d_l2_write", l2_write, d_kind != 0);
            check("d_l2_read",  l2_read,  d_kind == 0);
            check("d_l2_addr",  l2_addr,  d_addr);
            check("d_l2_wdata", l2_wdata, d_wdata);
            check("d_resp",     d_resp,   resp_now);
            check("d_other_i_resp", i_resp, 0);
            if (resp_now && d_kind == 0) check("d_rdata", d_rdata, ref_rd(d_addr));
        end
        if (i_resp) win_log.push_back(1);
        if (d_resp) win_log.push_back(2);
        if (i_resp || d_resp) begin
            gap_open = 1'b1;
            gap_cnt  = 0;
        end else if (gap_open) begin
            if (l2_read || l2_write) begin
                gap_log.push_back(gap_cnt);
                gap_open = 1'b0;
            end else begin
                gap_cnt++;
            end
        end
        if (owner == 0) begin
            nxt = 0;
            if (i_read && (d_read || d_write)) nxt = (last_win == 1) ? 2 : 1;
            else if (i_read) nxt = 1;
            else if (d_read || d_write) nxt = 2;
            if (nxt != 0) begin
                last_win = nxt;
                lat_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end
            owner = nxt;
        end else if (resp_now) begin
            if (owner == 2 && l2_write) l2_mem[32'(l2_addr)] = l2_wdata;
            if (owner == 2 && d_kind != 0) ref_mem[32'(d_addr)] = d_wdata;
            if (owner == 1) i_done = 1'b1;
            else d_done = 1'b1;
            completions++;
            owner = 0;
        end else begin
            lat_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input string tag, input int n, input int max_cycles);
        for (int k = 0; k < max_cycles && completions < n; k++) cycle();
        check({tag, "_completions"}, completions, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single I-side read of a known line.
        i_budget = 1; d_budget = 0; raise_pct = 100;
        force_lat = 3; use_fix_i = 1'b1; fix_i_addr = 16'h0040;
        ref_mem[32'h40] = {16{8'hA5}};
        l2_mem[32'h40]  = {16{8'hA5}};
        run_until("i_read", 1, 20);
        cycle();
        cycle();

        // Simultaneous I read and D write: I first after reset, then D.
        do_reset();
        i_budget = 1; d_budget = 1; raise_pct = 100; force_dkind = 1;
        run_until("tie", 2, 40);
        check("tie_count", win_log.size(), 2);
        if (win_log.size() >= 2) begin
            check("tie_first", win_log[0], 1);
            check("tie_second", win_log[1], 2);
        end

        // Both sides requesting continuously: strict alternation with one bubble.
        do_reset();
        i_budget = -1; d_budget = -1; raise_pct = 100;
        run_until("alt", 6, 100);
`ifdef L2_ARB_PERF_EN
        check("perf_i_grants", perf_i_grants, 3);
        check("perf_d_grants", perf_d_grants, 3);
        check("perf_conflicts", perf_conflicts, 6);
`endif
        check("alt_count", win_log.size(), 6);
        foreach (win_log[k]) check($sformatf("alt_order_%0d", k), win_log[k], (k % 2 == 0) ? 1 : 2);
        check("alt_gaps", gap_log.size(), 5);
        foreach (gap_log[k]) check($sformatf("alt_bubble_%0d", k), gap_log[k], 1);

        // D read+write together at 16'h1230 acts as a write, then read it back.
        do_reset();
        i_budget = 0; d_budget = 1; raise_pct = 100; force_dkind = 2;
        use_fix_d = 1'b1; fix_d_addr = 16'h1230;
        run_until("dual", 1, 20);
        d_budget = 1; force_dkind = 0;
        run_until("dual_rb", 2, 20);

        // Reset in the middle of a D transaction abandons it.
        do_reset();
        i_budget = 0; d_budget = 1; raise_pct = 100; force_dkind = 1; force_lat = 20;
        for (int k = 0; k < 10 && owner != 2; k++) cycle();
        check("mid_rst_granted_d", owner, 2);
        cycle();
        cycle();
        rst = 1'b1;
        l2_resp = 1'b0;
        #1;
        check("mid_rst_d_resp", d_resp, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_l2_write", l2_write, 0);
        check("post_rst_l2_addr", l2_addr, 0);
        check("post_rst_l2_wdata", l2_wdata, 0);
        check("post_rst_d_resp", d_resp, 0);
        model_reset();
        force_lat = -1;
        i_budget = 1; d_budget = 0;
        run_until("post_rst", 2, 40);
        check("post_rst_count", win_log.size(), 2);
        if (win_log.size() >= 1) check("post_rst_tie_i", win_log[0], 1);

        // Long randomized run.
        do_reset();
        i_budget = -1; d_budget = -1; raise_pct = 35;
        for (int k = 0; k < 3000; k++) cycle();
        check("rand_progress", completions > 50, 1);

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
